// File: rtl/mult_div_unit_if.sv
// Purpose : operand/result bundle between the execute-stage controller and
//           the multiply/divide unit.
// Signals : start  request strobe (controller -> unit)
//           op     3-bit operation code (controller -> unit)
//           A, B   32-bit operands (controller -> unit)
//           busy   operation in progress (unit -> controller)
//           HI, LO architectural HI/LO registers (unit -> controller)
// Modports: master = controller side, slave = multiply/divide unit side.
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, op, A, B, input  busy, HI, LO);
  modport slave  (input  start, op, A, B, output busy, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// Purpose : fixed-latency multiply/divide unit with HI/LO registers.
//           mult/multu/div/divu run for MULT_CYCLES/DIV_CYCLES busy cycles and
//           write HI/LO on the last one; mthi/mtlo write immediately.
// Ports   : clk    rising-edge clock
//           reset  synchronous, active-high reset
//           bus    mult_div_unit_if.slave (start, op, A, B in; busy, HI, LO out)
// Params  : MULT_CYCLES, DIV_CYCLES  busy length in cycles (>= 1)
//
// state  | meaning
// S_IDLE | waiting for a request; mthi/mtlo are serviced here
// S_BUSY | mult/div in flight, counter running down to the HI/LO write
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  mult_div_unit_if.slave   bus
);

  localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_N + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [1:0]         r_op;   // bit1: divide, bit0: unsigned
  logic               r_busy;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;

  // Result datapath works on the latched operands only.
  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic               w_b_nz;
  logic [31:0]        w_div_b;
  logic [31:0]        w_mag_a;
  logic [31:0]        w_mag_b;
  logic [31:0]        w_uq_s;
  logic [31:0]        w_ur_s;
  logic [31:0]        w_q_s;
  logic [31:0]        w_r_s;
  logic [31:0]        w_q_u;
  logic [31:0]        w_r_u;

  assign w_prod_s = $signed(r_a) * $signed(r_b);
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  // Divisor forced to 1 when zero so the divider never sees /0; the result is
  // discarded in that case anyway.
  assign w_b_nz  = |r_b;
  assign w_div_b = w_b_nz ? r_b : 32'd1;

  // Signed divide done on magnitudes then re-signed. 0x80000000 has magnitude
  // 0x80000000 as unsigned, so 0x80000000 / -1 wraps back to 0x80000000, rem 0.
  assign w_mag_a = r_a[31]     ? (~r_a + 32'd1)     : r_a;
  assign w_mag_b = w_div_b[31] ? (~w_div_b + 32'd1) : w_div_b;
  assign w_uq_s  = w_mag_a / w_mag_b;
  assign w_ur_s  = w_mag_a % w_mag_b;
  assign w_q_s   = (r_a[31] ^ w_div_b[31]) ? (~w_uq_s + 32'd1) : w_uq_s;
  assign w_r_s   = r_a[31] ? (~w_ur_s + 32'd1) : w_ur_s;

  assign w_q_u   = r_a / w_div_b;
  assign w_r_u   = r_a % w_div_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_busy  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (!bus.op[2]) begin
              r_a     <= bus.A;
              r_b     <= bus.B;
              r_op    <= bus.op[1:0];
              r_cnt   <= bus.op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
              r_busy  <= 1'b1;
              r_state <= S_BUSY;
            end else if (bus.op == 3'b100) begin
              r_hi <= bus.A;
            end else if (bus.op == 3'b101) begin
              r_lo <= bus.A;
            end
          end
        end

        S_BUSY: begin
          // Counter at 1 means this edge takes it to 0: write and release.
          if (r_cnt == CNT_W'(1)) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
            case (r_op)
              2'b00: {r_hi, r_lo} <= w_prod_s;
              2'b01: {r_hi, r_lo} <= w_prod_u;
              2'b10: if (w_b_nz) begin
                r_lo <= w_q_s;
                r_hi <= w_r_s;
              end
              default: if (w_b_nz) begin
                r_lo <= w_q_u;
                r_hi <= w_r_u;
              end
            endcase
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic reset;

  mult_div_unit_if bus();

  mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  // Reference model: updates exp_hi/exp_lo for an accepted op and returns the
  // expected busy length (0 for ops that do not occupy the unit).
  function automatic int model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = 64'(sa * sb); exp_hi = p[63:32]; exp_lo = p[31:0]; return MULT_N; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; return MULT_N; end
      3'd2: begin
        if (b != 0) begin
          q = sa / sb; r = sa % sb;
          exp_lo = q[31:0]; exp_hi = r[31:0];
        end
        return DIV_N;
      end
      3'd3: begin
        if (b != 0) begin exp_lo = a / b; exp_hi = a % b; end
        return DIV_N;
      end
      3'd4: begin exp_hi = a; return 0; end
      3'd5: begin exp_lo = a; return 0; end
      default: return 0;
    endcase
  endfunction

  // Issue one request starting just after a rising edge; returns just after the
  // edge on which busy falls (or after the accept edge for single-cycle ops).
  // inj > 0 pulses an idle-style mthi during that busy cycle, which must be ignored.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int inj);
    int          n, cnt;
    logic [31:0] old_hi, old_lo;
    logic        hold_ok;
    old_hi = exp_hi;
    old_lo = exp_lo;
    n = model(op, a, b);
    bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom; bus.op = 3'($urandom_range(0, 7));
    cnt = 0;
    hold_ok = 1'b1;
    while (bus.busy === 1'b1 && cnt < 60) begin
      cnt++;
      if (bus.HI !== old_hi || bus.LO !== old_lo) hold_ok = 1'b0;
      if (cnt == inj) begin
        bus.start = 1'b1; bus.op = 3'b100; bus.A = 32'h1234;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    chk({tag, "_busy_len"}, 64'(cnt), 64'(n));
    if (n > 0) chk({tag, "_hold"}, {63'd0, hold_ok}, 64'd1);
    chk({tag, "_hilo"}, {bus.HI, bus.LO}, {exp_hi, exp_lo});
  endtask

  initial begin
    int          op_r;
    logic [31:0] a_r, b_r;

    reset = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.A = '0; bus.B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {63'd0, bus.busy}, 64'd0);
    chk("reset_hilo", {bus.HI, bus.LO}, 64'd0);
    reset = 1'b0;

    do_op("t1_mult",  3'd0, 32'hFFFFFFFF, 32'd2, 0);
    chk("t1_exact", {bus.HI, bus.LO}, 64'hFFFFFFFF_FFFFFFFE);
    do_op("t2_multu", 3'd1, 32'hFFFFFFFF, 32'd2, 0);
    chk("t2_exact", {bus.HI, bus.LO}, 64'h00000001_FFFFFFFE);
    do_op("t3_div",   3'd2, 32'hFFFFFFF9, 32'd2, 0);
    chk("t3_exact", {bus.HI, bus.LO}, 64'hFFFFFFFF_FFFFFFFD);
    do_op("t3_divu",  3'd3, 32'hFFFFFFF9, 32'd2, 0);
    chk("t3u_exact", {bus.HI, bus.LO}, 64'h00000001_7FFFFFFC);

    do_op("t4_mthi",  3'd4, 32'h11, 32'd0, 0);
    do_op("t4_mtlo",  3'd5, 32'h22, 32'd0, 0);
    do_op("t4_divu0", 3'd3, 32'd7, 32'd0, 0);
    chk("t4_exact", {bus.HI, bus.LO}, 64'h00000011_00000022);
    do_op("t4_div0",  3'd2, 32'h80000000, 32'd0, 0);

    do_op("ovf_div",  3'd2, 32'h80000000, 32'hFFFFFFFF, 0);
    chk("ovf_exact", {bus.HI, bus.LO}, 64'h00000000_80000000);

    do_op("t5_mult",  3'd0, 32'd1000, 32'hFFFFFFFD, 2);
    do_op("t5_mthi",  3'd4, 32'h1234, 32'd0, 0);
    chk("t5_hi", 64'(bus.HI), 64'h1234);

    do_op("rsv6", 3'd6, 32'hDEADBEEF, 32'd1, 0);
    do_op("rsv7", 3'd7, 32'hCAFEF00D, 32'd1, 0);

    // Reset during busy cycle 3 of a divide: aborts with no write.
    void'(model(3'd2, 32'd100, 32'd7));
    bus.start = 1'b1; bus.op = 3'd2; bus.A = 32'd100; bus.B = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_busy_before", {63'd0, bus.busy}, 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    chk("t6_busy", {63'd0, bus.busy}, 64'd0);
    chk("t6_hilo", {bus.HI, bus.LO}, 64'd0);
    repeat (DIV_N + 3) @(posedge clk);
    #1;
    chk("t6_no_late_write", {bus.HI, bus.LO}, 64'd0);

    for (int i = 0; i < 40; i++) begin
      op_r = $urandom_range(0, 7);
      a_r  = $urandom;
      case ($urandom_range(0, 5))
        0: b_r = 32'd0;
        1: b_r = 32'($urandom_range(1, 9));
        2: begin a_r = 32'h80000000; b_r = 32'hFFFFFFFF; end
        default: b_r = $urandom;
      endcase
      do_op("rand", 3'(op_r), a_r, b_r, (i % 4 == 0) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
